// File: rtl/gb_host_master.sv
// Ghostbus initiator: converts host command beats into ghostbus write/read strobes
// and returns read data (with auto-incrementing bursts) as a response stream.
module gb_host_master #(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned LW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          idle_q;

    logic [AW-1:0] gb_addr_d;
    logic [DW-1:0] gb_wdata_d;
    logic [DW-1:0] rsp_data_d;
    logic          gb_wen_d, gb_rstb_d, rsp_valid_d, rsp_last_d, busy_d, idle_d;

    // idle_q is registered; the reset term keeps ready low while reset is held
    assign cmd_ready = idle_q & ~gb_rst;

    // Next state; strobe/response registers are loaded from the state being entered
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rem_d   = cmd_len;
                    state_d = cmd_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                cnt_d   = CW'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = gb_rdata;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        rem_d   = rem_q - LW'(1);
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        gb_wen_d    = (state_d == S_WRITE);
        gb_rstb_d   = (state_d == S_READ);
        rsp_valid_d = (state_d == S_RESP);
        rsp_last_d  = (state_d == S_RESP) && (rem_d == '0);
        busy_d      = (state_d != S_IDLE);
        idle_d      = (state_d == S_IDLE);
        gb_addr_d   = (gb_wen_d || gb_rstb_d) ? addr_d : gb_addr;
        gb_wdata_d  = gb_wen_d ? wdata_d : gb_wdata;
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            idle_q    <= 1'b1;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            gb_addr   <= gb_addr_d;
            gb_wdata  <= gb_wdata_d;
            gb_wen    <= gb_wen_d;
            gb_rstb   <= gb_rstb_d;
            rsp_valid <= rsp_valid_d;
            rsp_last  <= rsp_last_d;
            rsp_data  <= rsp_data_d;
            busy      <= busy_d;
        end
    end

endmodule
